// File: rtl/memreg_axis_bridge.sv
// Register bank bridging host register accesses
// to AXI4-Stream TX/RX ports through two FIFOs.
module memreg_axis_bridge #(
  parameter int FIFO_DEPTH = 16,
  parameter logic [31:0] ID_VALUE = 32'h4158_5342
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] wdata,
  input  logic [2:0]  waddr,
  input  logic        wvalid,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  logic        tx_en, rx_en, irq_en;
  logic        tx_en_n, rx_en_n, irq_en_n;
  logic        tx_ovf, rx_udf, tx_hold;
  logic [31:0] tx_count;

  logic [32:0] tx_mem [FIFO_DEPTH];
  logic [32:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr, tx_rptr, tx_wptr_n, tx_rptr_n;
  logic [AW:0] rx_wptr, rx_rptr, rx_wptr_n, rx_rptr_n;
  logic [AW:0] tx_level, rx_level, rx_level_n;
  logic        tx_full, tx_empty, rx_full, rx_empty;

  logic wr_ctrl, wr_stat, wr_txd, wr_txl;
  logic wr_pop, wr_cnt;
  logic tx_flush, rx_flush;
  logic tx_push_req, tx_push, tx_hs;
  logic rx_push, rx_pop;
  logic [32:0] tx_head, rx_head;

  assign wr_ctrl = wvalid && (waddr == 3'd0);
  assign wr_stat = wvalid && (waddr == 3'd1);
  assign wr_txd  = wvalid && (waddr == 3'd2);
  assign wr_txl  = wvalid && (waddr == 3'd3);
  assign wr_pop  = wvalid && (waddr == 3'd5);
  assign wr_cnt  = wvalid && (waddr == 3'd6);

  assign tx_flush = wr_ctrl && wdata[2];
  assign rx_flush = wr_ctrl && wdata[3];

  assign tx_level = tx_wptr - tx_rptr;
  assign rx_level = rx_wptr - rx_rptr;
  assign tx_full  = (tx_level == DEPTH);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == DEPTH);
  assign rx_empty = (rx_level == '0);

  assign tx_head = tx_mem[tx_rptr[AW-1:0]];
  assign rx_head = rx_mem[rx_rptr[AW-1:0]];

  assign m_axis_tvalid = !tx_empty && (tx_en || tx_hold);
  assign m_axis_tdata  = tx_head[31:0];
  assign m_axis_tlast  = tx_head[32];

  assign tx_hs       = m_axis_tvalid && m_axis_tready;
  assign tx_push_req = wr_txd || wr_txl;
  assign tx_push     = tx_push_req && (!tx_full || tx_hs);
  assign rx_push     = s_axis_tvalid && s_axis_tready;
  assign rx_pop      = wr_pop && !rx_empty;

  // Next control bits; flush bits are pulses, never stored
  always_comb begin
    tx_en_n  = tx_en;
    rx_en_n  = rx_en;
    irq_en_n = irq_en;
    if (wr_ctrl) begin
      tx_en_n  = wdata[0];
      rx_en_n  = wdata[1];
      irq_en_n = wdata[4];
    end
  end

  // Next FIFO pointers; flush wins over push/pop
  always_comb begin
    tx_wptr_n = tx_wptr;
    tx_rptr_n = tx_rptr;
    rx_wptr_n = rx_wptr;
    rx_rptr_n = rx_rptr;
    if (tx_flush) begin
      tx_wptr_n = '0;
      tx_rptr_n = '0;
    end else begin
      if (tx_push) tx_wptr_n = tx_wptr + 1'b1;
      if (tx_hs)   tx_rptr_n = tx_rptr + 1'b1;
    end
    if (rx_flush) begin
      rx_wptr_n = '0;
      rx_rptr_n = '0;
    end else begin
      if (rx_push) rx_wptr_n = rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr_n = rx_rptr + 1'b1;
    end
  end

  assign rx_level_n = rx_wptr_n - rx_rptr_n;

  // Control, flags, pointers and stream-side state
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      tx_en         <= 1'b0;
      rx_en         <= 1'b0;
      irq_en        <= 1'b0;
      tx_ovf        <= 1'b0;
      rx_udf        <= 1'b0;
      tx_hold       <= 1'b0;
      tx_count      <= '0;
      tx_wptr       <= '0;
      tx_rptr       <= '0;
      rx_wptr       <= '0;
      rx_rptr       <= '0;
      s_axis_tready <= 1'b0;
      irq           <= 1'b0;
    end else begin
      tx_en   <= tx_en_n;
      rx_en   <= rx_en_n;
      irq_en  <= irq_en_n;
      tx_wptr <= tx_wptr_n;
      tx_rptr <= tx_rptr_n;
      rx_wptr <= rx_wptr_n;
      rx_rptr <= rx_rptr_n;
      if (wr_stat && wdata[20])
        tx_ovf <= 1'b0;
      else if (tx_push_req && !tx_push)
        tx_ovf <= 1'b1;
      if (wr_stat && wdata[21])
        rx_udf <= 1'b0;
      else if (wr_pop && rx_empty)
        rx_udf <= 1'b1;
      if (tx_flush || tx_hs)
        tx_hold <= 1'b0;
      else if (m_axis_tvalid)
        tx_hold <= 1'b1;
      if (wr_cnt)
        tx_count <= '0;
      else if (tx_hs)
        tx_count <= tx_count + 32'd1;
      s_axis_tready <= rx_en_n && (rx_level_n != DEPTH);
      irq <= irq_en &&
             (!rx_empty || tx_ovf || rx_udf);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge axis_aclk) begin
    if (tx_push && !tx_flush)
      tx_mem[tx_wptr[AW-1:0]] <= {wr_txl, wdata};
    if (rx_push && !rx_flush)
      rx_mem[rx_wptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Side-effect-free read mux
  always_comb begin
    rdata = '0;
    case (raddr)
      3'd0: rdata = {27'd0, irq_en, 2'b00, rx_en, tx_en};
      3'd1: begin
        rdata[4:0]  = 5'(tx_level);
        rdata[12:8] = 5'(rx_level);
        rdata[16]   = tx_full;
        rdata[17]   = tx_empty;
        rdata[18]   = rx_full;
        rdata[19]   = rx_empty;
        rdata[20]   = tx_ovf;
        rdata[21]   = rx_udf;
        rdata[22]   = !rx_empty && rx_head[32];
      end
      3'd4: rdata = rx_empty ? 32'd0 : rx_head[31:0];
      3'd6: rdata = tx_count;
      3'd7: rdata = ID_VALUE;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_memreg_axis_bridge.sv
// Scoreboard bench for memreg_axis_bridge.
// TX beats checked by a monitor, RX by register pops.
module tb_memreg_axis_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wdata = '0;
  logic [2:0]  waddr = '0;
  logic        wvalid = 1'b0;
  logic [2:0]  raddr = '0;
  logic [31:0] rdata;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        irq;

  int errs = 0;
  int checks = 0;
  int tx_seen = 0;
  logic [32:0] txq [$];
  logic [32:0] rxq [$];

  always #5 clk = ~clk;

  memreg_axis_bridge dut (
    .axis_aclk(clk),
    .axis_aresetn(rst_n),
    .wdata(wdata),
    .waddr(waddr),
    .wvalid(wvalid),
    .raddr(raddr),
    .rdata(rdata),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .irq(irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    wvalid = 1'b1;
    waddr  = a;
    wdata  = d;
    tick();
    wvalid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [31:0] d);
    raddr = a;
    #1;
    d = rdata;
  endtask

  task automatic send_beat(input logic [31:0] d,
                           input logic l);
    logic acc;
    acc = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = s_tready;
      tick();
    end
    s_tvalid = 1'b0;
    if (acc) rxq.push_back({l, d});
    chk("rx_accept", 32'(acc), 32'd1);
  endtask

  // TX monitor: beat is taken at the next rising edge
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && m_tvalid && m_tready) begin
      tx_seen++;
      if (txq.size() == 0) begin
        chk("tx_unexp", m_tdata, 32'hxxxx_xxxx);
      end else begin
        e = txq.pop_front();
        chk("tx_data", m_tdata, e[31:0]);
        chk("tx_last", 32'(m_tlast), 32'(e[32]));
      end
    end
  end

  localparam logic [31:0] ST_EMPTY = 32'h000A_0000;

  initial begin
    logic [31:0] v;
    logic [32:0] e;
    logic acc;
    int nacc;

    repeat (3) tick();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    tick();
    rd(0, v); chk("rst_ctrl", v, 32'd0);
    rd(1, v); chk("rst_status", v, ST_EMPTY);
    rd(2, v); chk("rst_txdata", v, 32'd0);
    rd(4, v); chk("rst_rxdata", v, 32'd0);
    rd(5, v); chk("rst_rxpop", v, 32'd0);
    rd(6, v); chk("rst_txcount", v, 32'd0);
    rd(7, v); chk("rst_id", v, 32'h4158_5342);
    chk("rst_irq", 32'(irq), 32'd0);

    // TX stream
    m_tready = 1'b1;
    wr(0, 32'd1);
    txq.push_back({1'b0, 32'h11}); wr(2, 32'h11);
    txq.push_back({1'b0, 32'h22}); wr(2, 32'h22);
    txq.push_back({1'b1, 32'h33}); wr(3, 32'h33);
    for (int n = 0; n < 20 && txq.size() != 0; n++)
      tick();
    tick();
    chk("tx_drain", 32'(txq.size()), 32'd0);
    chk("tx_seen", 32'(tx_seen), 32'd3);
    rd(6, v); chk("txcount3", v, 32'd3);
    rd(1, v); chk("tx_empty", v, ST_EMPTY);

    // TX overflow with backpressure
    m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) txq.push_back({1'b0, 32'h200 + 32'(i)});
      wr(2, 32'h200 + 32'(i));
    end
    rd(1, v);
    chk("ovf_status", v, 32'h10 | (32'd1 << 16) |
        (32'd1 << 19) | (32'd1 << 20));
    chk("ovf_tvalid", 32'(m_tvalid), 32'd1);
    wr(0, 32'd0);
    tick(); tick();
    chk("hold_tvalid", 32'(m_tvalid), 32'd1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("hold_drop", 32'(m_tvalid), 32'd0);
    chk("hold_seen", 32'(tx_seen), 32'd4);
    wr(1, 32'd1 << 20);
    rd(1, v);
    chk("ovf_clear", v, 32'hF | (32'd1 << 19));
    rd(6, v); chk("txcount4", v, 32'd4);
    wr(6, 32'hFFFF_FFFF);
    rd(6, v); chk("txcount_clr", v, 32'd0);
    wr(0, 32'd4);
    txq.delete();
    rd(1, v); chk("tx_flush", v, ST_EMPTY);

    // RX stream with interrupt
    wr(0, 32'd2 | 32'd16);
    send_beat(32'hA5, 1'b1);
    chk("irq_lat0", 32'(irq), 32'd0);
    tick();
    chk("irq_lat1", 32'(irq), 32'd1);
    e = rxq.pop_front();
    rd(4, v); chk("rx_data", v, e[31:0]);
    rd(1, v); chk("rx_tlast", 32'(v[22]), 32'(e[32]));
    wr(5, 32'd0);
    tick();
    chk("irq_off", 32'(irq), 32'd0);
    rd(1, v); chk("rx_empty", v, ST_EMPTY);
    wr(5, 32'd0);
    tick();
    chk("irq_udf", 32'(irq), 32'd1);
    rd(1, v); chk("udf_status", v, ST_EMPTY | (32'd1 << 21));
    wr(1, 32'd1 << 21);
    tick();
    chk("irq_clr", 32'(irq), 32'd0);

    // RX fill under continuous valid
    wr(0, 32'd2);
    nacc = 0;
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    for (int n = 0; n < 30; n++) begin
      s_tdata = 32'h100 + 32'(nacc);
      acc = s_tready;
      tick();
      if (acc) begin
        rxq.push_back({1'b0, s_tdata});
        nacc++;
      end
    end
    chk("rx_fill_cnt", 32'(nacc), 32'd16);
    chk("rx_full_rdy", 32'(s_tready), 32'd0);
    rd(1, v);
    chk("rx_full_st", v, 32'h1000 | (32'd1 << 17) | (32'd1 << 18));

    // Pops racing incoming beats
    for (int n = 0; n < 4; n++) begin
      rd(4, v);
      e = rxq.pop_front();
      chk("rx_pop_data", v, e[31:0]);
      s_tdata = 32'h100 + 32'(nacc);
      wvalid = 1'b1;
      waddr  = 3'd5;
      acc = s_tready;
      tick();
      wvalid = 1'b0;
      if (acc) begin
        rxq.push_back({1'b0, s_tdata});
        nacc++;
      end
    end
    rd(1, v);
    chk("rx_lvl_same", 32'(v[12:8]), 32'(rxq.size()));
    s_tdata = 32'h100 + 32'(nacc);
    acc = s_tready;
    tick();
    if (acc) rxq.push_back({1'b0, s_tdata});
    s_tvalid = 1'b0;
    rd(1, v);
    chk("rx_lvl_refill", 32'(v[12:8]), 32'd16);
    chk("rx_model_lvl", 32'(rxq.size()), 32'd16);
    chk("rx_refill_rdy", 32'(s_tready), 32'd0);
    rd(4, v);
    e = rxq[0];
    chk("rx_order", v, e[31:0]);

    // RX flush with 5 entries
    wr(0, 32'd2 | 32'd8);
    rxq.delete();
    for (int i = 0; i < 5; i++)
      send_beat(32'h300 + 32'(i), 1'b0);
    rd(1, v); chk("rx_lvl5", 32'(v[12:8]), 32'd5);
    wr(0, 32'd2 | 32'd8);
    rxq.delete();
    rd(1, v); chk("rx_flush_st", v, ST_EMPTY);
    chk("rx_flush_rdy", 32'(s_tready), 32'd1);

    // Async reset during a TX beat
    wr(0, 32'd1);
    txq.push_back({1'b0, 32'h77});
    wr(2, 32'h77);
    chk("pre_rst_tv", 32'(m_tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tv", 32'(m_tvalid), 32'd0);
    txq.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    rd(0, v); chk("post_ctrl", v, 32'd0);
    rd(1, v); chk("post_status", v, ST_EMPTY);
    rd(6, v); chk("post_txcount", v, 32'd0);
    chk("post_tready", 32'(s_tready), 32'd0);
    chk("post_tvalid", 32'(m_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
